// File: rtl/eth_apb_pkg.sv
// eth_apb_pkg: shared constants and types for the Ethernet MAC APB register file.
//   - byte addresses of the control registers and of the BD window
//   - reset-value constants
//   - APB transfer state encoding
package eth_apb_pkg;

  localparam logic [31:0] ADDR_MODER      = 32'h0000_0000;
  localparam logic [31:0] ADDR_INT_SOURCE = 32'h0000_0004;
  localparam logic [31:0] ADDR_INT_MASK   = 32'h0000_0008;
  localparam logic [31:0] ADDR_TX_BD_NUM  = 32'h0000_0020;
  localparam logic [31:0] ADDR_MIIADDRESS = 32'h0000_0030;
  localparam logic [31:0] ADDR_MAC_ADDR0  = 32'h0000_0040;
  localparam logic [31:0] ADDR_MAC_ADDR1  = 32'h0000_0044;
  localparam logic [31:0] BD_BASE         = 32'h0000_0400;

  localparam logic [31:0] MODER_RST_DEF   = 32'h0000_A000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // TX_BD_NUM resets to half the descriptor table (TX and RX halves).
  function automatic logic [7:0] tx_bd_num_rst(input int n_bd);
    return 8'(n_bd / 2);
  endfunction

endpackage

// File: rtl/eth_bd_ram.sv
// eth_bd_ram: true dual-port DEPTH x 32 descriptor RAM.
//   Host port : h_re_i loads h_rdata_o from h_addr_i; h_we_i writes h_wdata_i.
//   Core port : c_rdata_o is registered from c_addr_i every cycle (write-first);
//               c_we_i writes c_wdata_i.
//   When both ports write the same word in one cycle, the core write is kept.
//   Memory contents are not reset; only the read registers are.
module eth_bd_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          h_re_i,
  input  logic          h_we_i,
  input  logic [AW-1:0] h_addr_i,
  input  logic [31:0]   h_wdata_i,
  output logic [31:0]   h_rdata_o,
  input  logic          c_we_i,
  input  logic [AW-1:0] c_addr_i,
  input  logic [31:0]   c_wdata_i,
  output logic [31:0]   c_rdata_o
);

  logic [31:0] mem [DEPTH];
  logic        h_blocked;

  assign h_blocked = c_we_i && (c_addr_i == h_addr_i);

  always_ff @(posedge clk_i) begin
    if (c_we_i) mem[c_addr_i] <= c_wdata_i;
    if (h_we_i && !h_blocked) mem[h_addr_i] <= h_wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_rdata_o <= '0;
      h_rdata_o <= '0;
    end else begin
      c_rdata_o <= c_we_i ? c_wdata_i : mem[c_addr_i];
      if (h_re_i) h_rdata_o <= mem[h_addr_i];
    end
  end

endmodule

// File: rtl/eth_apb_regfile.sv
// eth_apb_regfile: APB slave register file plus buffer-descriptor store.
//   APB    : pclk_i/prstn_i, psel/penable/pwrite/paddr/pwdata in,
//            prdata/pready/pslverr out (WAIT_STATES extra ACCESS cycles).
//   IRQ    : int_event_i sets INT_SOURCE bits, int_o = registered |(src & mask).
//   Config : moder_o, tx_bd_num_o, mac_addr_o, miiaddress_o.
//   BD     : core port bd_addr_i/bd_we_i/bd_wdata_i/bd_rdata_o into the BD RAM
//            that the host sees at BD_BASE.
module eth_apb_regfile
  import eth_apb_pkg::*;
#(
  parameter int          N_INT       = 7,
  parameter int          N_BD        = 128,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] MODER_RST   = MODER_RST_DEF,
  localparam int         BD_AW       = $clog2(2 * N_BD)
) (
  input  logic             pclk_i,
  input  logic             prstn_i,
  input  logic             psel_i,
  input  logic             penable_i,
  input  logic             pwrite_i,
  input  logic [31:0]      paddr_i,
  input  logic [31:0]      pwdata_i,
  output logic [31:0]      prdata_o,
  output logic             pready_o,
  output logic             pslverr_o,
  output logic             int_o,
  input  logic [N_INT-1:0] int_event_i,
  output logic [31:0]      moder_o,
  output logic [7:0]       tx_bd_num_o,
  output logic [47:0]      mac_addr_o,
  output logic [31:0]      miiaddress_o,
  input  logic [BD_AW-1:0] bd_addr_i,
  input  logic             bd_we_i,
  input  logic [31:0]      bd_wdata_i,
  output logic [31:0]      bd_rdata_o
);

  localparam logic [2:0]  WAIT_LAST = 3'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
  localparam logic [31:0] BD_END    = BD_BASE + 32'(8 * N_BD);

  apb_state_e       state_q, state_d, phase;
  logic             pready_q, pready_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic             write_q, write_d;
  logic [31:0]      moder_q, moder_d, mii_q, mii_d, mac0_q, mac0_d;
  logic [15:0]      mac1_q, mac1_d;
  logic [7:0]       tx_bd_num_q, tx_bd_num_d;
  logic [N_INT-1:0] int_src_q, int_src_d, int_mask_q, int_mask_d, w1c;
  logic             int_q, int_d;

  logic hit_moder, hit_isrc, hit_imask, hit_txbd, hit_mii, hit_mac0, hit_mac1, hit_bd, hit_any;
  logic commit;
  logic [31:0] rdata, bd_host_rdata;
  logic unused_addr_bits;

  assign unused_addr_bits = ^paddr_i[1:0];

  // Address decode always works from the address latched in SETUP.
  assign hit_moder = (addr_q == ADDR_MODER);
  assign hit_isrc  = (addr_q == ADDR_INT_SOURCE);
  assign hit_imask = (addr_q == ADDR_INT_MASK);
  assign hit_txbd  = (addr_q == ADDR_TX_BD_NUM);
  assign hit_mii   = (addr_q == ADDR_MIIADDRESS);
  assign hit_mac0  = (addr_q == ADDR_MAC_ADDR0);
  assign hit_mac1  = (addr_q == ADDR_MAC_ADDR1);
  assign hit_bd    = (addr_q >= BD_BASE) && (addr_q < BD_END);
  assign hit_any   = hit_moder | hit_isrc | hit_imask | hit_txbd | hit_mii |
                     hit_mac0 | hit_mac1 | hit_bd;

  // The write lands on the edge that closes the pready cycle.
  assign commit = (state_q == ACCESS) && pready_q && write_q;

  // The stored state is IDLE or ACCESS; SETUP is the cycle in which an idle
  // slave sees psel without penable, so it is decoded from the bus.
  always_comb begin
    state_d  = state_q;
    pready_d = 1'b0;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    phase    = state_q;
    if (state_q == IDLE && psel_i && !penable_i) phase = SETUP;
    case (phase)
      IDLE: state_d = IDLE;
      SETUP: begin
        state_d  = ACCESS;
        addr_d   = {paddr_i[31:2], 2'b00};
        wdata_d  = pwdata_i;
        write_d  = pwrite_i;
        wcnt_d   = '0;
        pready_d = (WAIT_STATES == 0);
      end
      ACCESS: begin
        if (pready_q || !psel_i) state_d = IDLE;  // done, or aborted
        else if (wcnt_q == WAIT_LAST) pready_d = 1'b1;
        else wcnt_d = wcnt_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    moder_d     = (commit && hit_moder) ? wdata_q : moder_q;
    int_mask_d  = (commit && hit_imask) ? wdata_q[N_INT-1:0] : int_mask_q;
    mii_d       = (commit && hit_mii)   ? wdata_q : mii_q;
    mac0_d      = (commit && hit_mac0)  ? wdata_q : mac0_q;
    mac1_d      = (commit && hit_mac1)  ? wdata_q[15:0] : mac1_q;
    tx_bd_num_d = tx_bd_num_q;
    if (commit && hit_txbd && (wdata_q <= 32'(N_BD))) tx_bd_num_d = wdata_q[7:0];
    // Events are OR-ed after the clear, so a same-cycle event survives it.
    w1c         = (commit && hit_isrc) ? wdata_q[N_INT-1:0] : '0;
    int_src_d   = (int_src_q & ~w1c) | int_event_i;
    int_d       = |(int_src_q & int_mask_q);
  end

  always_comb begin
    rdata = '0;
    if (hit_moder)      rdata = moder_q;
    else if (hit_isrc)  rdata[N_INT-1:0] = int_src_q;
    else if (hit_imask) rdata[N_INT-1:0] = int_mask_q;
    else if (hit_txbd)  rdata[7:0] = tx_bd_num_q;
    else if (hit_mii)   rdata = mii_q;
    else if (hit_mac0)  rdata = mac0_q;
    else if (hit_mac1)  rdata[15:0] = mac1_q;
    else if (hit_bd)    rdata = bd_host_rdata;
  end

  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      state_q     <= IDLE;
      pready_q    <= 1'b0;
      wcnt_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      moder_q     <= MODER_RST;
      int_src_q   <= '0;
      int_mask_q  <= '0;
      tx_bd_num_q <= tx_bd_num_rst(N_BD);
      mii_q       <= '0;
      mac0_q      <= '0;
      mac1_q      <= '0;
      int_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pready_q    <= pready_d;
      wcnt_q      <= wcnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      moder_q     <= moder_d;
      int_src_q   <= int_src_d;
      int_mask_q  <= int_mask_d;
      tx_bd_num_q <= tx_bd_num_d;
      mii_q       <= mii_d;
      mac0_q      <= mac0_d;
      mac1_q      <= mac1_d;
      int_q       <= int_d;
    end
  end

  // Host port reads in SETUP from the live bus address and writes on commit
  // from the latched one; the two never coincide.
  eth_bd_ram #(.DEPTH(2 * N_BD), .AW(BD_AW)) u_bd_ram (
    .clk_i     (pclk_i),
    .rst_ni    (prstn_i),
    .h_re_i    (phase == SETUP),
    .h_we_i    (commit && hit_bd),
    .h_addr_i  (commit ? addr_q[BD_AW+1:2] : paddr_i[BD_AW+1:2]),
    .h_wdata_i (wdata_q),
    .h_rdata_o (bd_host_rdata),
    .c_we_i    (bd_we_i),
    .c_addr_i  (bd_addr_i),
    .c_wdata_i (bd_wdata_i),
    .c_rdata_o (bd_rdata_o)
  );

  assign pready_o     = pready_q;
  assign pslverr_o    = pready_q & ~hit_any;
  assign prdata_o     = pready_q ? rdata : '0;
  assign int_o        = int_q;
  assign moder_o      = moder_q;
  assign tx_bd_num_o  = tx_bd_num_q;
  assign mac_addr_o   = {mac1_q, mac0_q};
  assign miiaddress_o = mii_q;

endmodule

// File: tb/tb_eth_apb_regfile.sv
// Testbench for eth_apb_regfile (N_INT=7, N_BD=128, WAIT_STATES=1).
// The stimulus tasks push the expected APB response into a queue; a monitor
// pops and compares whenever pready_o is high. Side-band outputs are checked
// directly against hand-computed constants.
module tb_eth_apb_regfile;

  localparam int N_INT = 7;
  localparam int N_BD  = 128;
  localparam int W     = 1;

  logic             pclk = 1'b0;
  logic             prstn = 1'b0;
  logic             psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0]      paddr = '0, pwdata = '0;
  logic [31:0]      prdata;
  logic             pready, pslverr, int_o;
  logic [N_INT-1:0] int_event = '0;
  logic [31:0]      moder, miiaddress;
  logic [7:0]       tx_bd_num;
  logic [47:0]      mac_addr;
  logic [7:0]       bd_addr = '0;
  logic             bd_we = 1'b0;
  logic [31:0]      bd_wdata = '0, bd_rdata;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] rd;
    logic        err;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 pclk = ~pclk;

  eth_apb_regfile #(.N_INT(N_INT), .N_BD(N_BD), .WAIT_STATES(W),
                    .MODER_RST(32'h0000_A000)) dut (
    .pclk_i(pclk), .prstn_i(prstn),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .int_o(int_o), .int_event_i(int_event),
    .moder_o(moder), .tx_bd_num_o(tx_bd_num), .mac_addr_o(mac_addr),
    .miiaddress_o(miiaddress),
    .bd_addr_i(bd_addr), .bd_we_i(bd_we), .bd_wdata_i(bd_wdata),
    .bd_rdata_o(bd_rdata)
  );

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Scoreboard monitor: one expectation per completed transfer.
  always @(negedge pclk) begin
    if (prstn && pready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pready", 64'(paddr), 64'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("pslverr@%0h", mon_e.addr), 64'(pslverr), 64'(mon_e.err));
        if (!mon_e.wr) chk($sformatf("prdata@%0h", mon_e.addr), 64'(prdata), 64'(mon_e.rd));
      end
    end
  end

  // One APB transfer. ev/cwe/caddr/cdata are applied during the pready cycle.
  task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input logic [N_INT-1:0] ev = '0, input logic cwe = 1'b0,
                     input logic [7:0] caddr = '0, input logic [31:0] cdata = '0);
    int cyc;
    exp_t e;
    e.wr = wr; e.addr = a; e.rd = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc = 1;
    forever begin
      @(negedge pclk);
      if (pready) break;
      if (cyc > 20) begin
        chk("pready_timeout", 64'(cyc), 64'(W + 1));
        break;
      end
      @(posedge pclk); #1;
      cyc++;
    end
    chk($sformatf("access_cycles@%0h", a), 64'(cyc), 64'(W + 1));
    $display("txn %s addr=%08h wdata=%08h prdata=%08h pslverr=%0b",
             wr ? "WR" : "RD", a, d, prdata, pslverr);
    int_event = ev; bd_we = cwe;
    if (cwe) begin bd_addr = caddr; bd_wdata = cdata; end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; int_event = '0; bd_we = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_pready", 64'(pready), 64'h0);
    chk("rst_prdata", 64'(prdata), 64'h0);
    chk("rst_moder", 64'(moder), 64'h0000_A000);
    chk("rst_tx_bd_num", 64'(tx_bd_num), 64'h40);
    chk("rst_mac_addr", 64'(mac_addr), 64'h0);
    chk("rst_int", 64'(int_o), 64'h0);
    #1 prstn = 1'b1;

    // Reset values via the bus.
    apb(0, 32'h00, 0, 32'h0000_A000, 0);
    apb(0, 32'h04, 0, 32'h0, 0);
    apb(0, 32'h08, 0, 32'h0, 0);
    apb(0, 32'h20, 0, 32'h40, 0);
    apb(0, 32'h30, 0, 32'h0, 0);
    apb(0, 32'h40, 0, 32'h0, 0);
    apb(0, 32'h44, 0, 32'h0, 0);

    // MAC address and MII registers.
    apb(1, 32'h40, 32'h1122_3344, 0, 0);
    apb(1, 32'h44, 32'hFFFF_5566, 0, 0);
    @(negedge pclk);
    chk("mac_addr_o", 64'(mac_addr), 64'h5566_1122_3344);
    apb(0, 32'h44, 0, 32'h0000_5566, 0);
    apb(1, 32'h30, 32'h1234_5678, 0, 0);
    chk("miiaddress_o", 64'(miiaddress), 64'h1234_5678);

    // Interrupts: mask 0x05, events 0x07, int_o one cycle behind the source.
    apb(1, 32'h08, 32'h05, 0, 0);
    @(posedge pclk); #1 int_event = 7'h07;
    @(posedge pclk); #1 int_event = '0;
    @(negedge pclk);
    chk("int_o_lag", 64'(int_o), 64'h0);
    @(negedge pclk);
    chk("int_o_set", 64'(int_o), 64'h1);
    apb(0, 32'h04, 0, 32'h07, 0);
    // Clear 0x05 while event bit 0 fires: bit 0 stays, bit 2 clears.
    apb(1, 32'h04, 32'h05, 0, 0, 7'h01);
    apb(0, 32'h04, 0, 32'h03, 0);
    chk("int_o_stays", 64'(int_o), 64'h1);

    // BD memory: host write, core read.
    apb(1, 32'h408, 32'hDEAD_BEEF, 0, 0);
    @(posedge pclk); #1 bd_addr = 8'd2;
    @(posedge pclk); @(negedge pclk);
    chk("core_rd_idx2", 64'(bd_rdata), 64'hDEAD_BEEF);
    apb(0, 32'h408, 0, 32'hDEAD_BEEF, 0);
    // Same-word collision: core value wins, host sees no error.
    apb(1, 32'h408, 32'h1, 0, 0, '0, 1'b1, 8'd2, 32'h2);
    apb(0, 32'h408, 0, 32'h2, 0);
    @(negedge pclk);
    chk("core_rd_collide", 64'(bd_rdata), 64'h2);
    // Core write-first on index 5, then host reads it at 0x414.
    @(posedge pclk); #1 bd_addr = 8'd5; bd_wdata = 32'hCAFE_0005; bd_we = 1'b1;
    @(posedge pclk); #1 bd_we = 1'b0;
    @(negedge pclk);
    chk("core_write_first", 64'(bd_rdata), 64'hCAFE_0005);
    apb(0, 32'h414, 0, 32'hCAFE_0005, 0);
    // Last BD word and first address past the window.
    apb(1, 32'h7FC, 32'hA5A5_A5A5, 0, 0);
    apb(0, 32'h7FC, 0, 32'hA5A5_A5A5, 0);
    apb(0, 32'h800, 0, 32'h0, 1);

    // TX_BD_NUM bounds and unmapped addresses.
    apb(1, 32'h20, 32'h81, 0, 0);
    apb(0, 32'h20, 0, 32'h40, 0);
    apb(1, 32'h20, 32'h80, 0, 0);
    chk("tx_bd_num_o", 64'(tx_bd_num), 64'h80);
    apb(0, 32'h10, 0, 32'h0, 1);
    apb(1, 32'h10, 32'hFFFF_FFFF, 0, 1);

    // Reset in the middle of a MODER write drops it.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h0000_1234;
    @(posedge pclk); #1 penable = 1'b1;
    #2 prstn = 1'b0;
    @(negedge pclk);
    chk("midrst_pready", 64'(pready), 64'h0);
    chk("midrst_moder", 64'(moder), 64'h0000_A000);
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1 prstn = 1'b1;
    apb(0, 32'h00, 0, 32'h0000_A000, 0);
    apb(1, 32'h00, 32'h0000_5555, 0, 0);
    chk("moder_o_after", 64'(moder), 64'h0000_5555);
    apb(0, 32'h00, 0, 32'h0000_5555, 0);

    repeat (3) @(posedge pclk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
